// File: rtl/ft245_responder.sv
// FT245 FIFO-chip side: answers the master's rd_n/wr_n strobes, drives rxf_n/txe_n, buffers bytes in RX/TX FIFOs.
// Define FT245_LOOPBACK_EN to echo every master write straight back into the RX FIFO.
module ft245_responder #(
  parameter int DEPTH_LOG2 = 4,
  parameter int PRECHARGE  = 2
) (
  input  logic       clock_in,
  input  logic       reset,
  inout  wire  [7:0] in_out_245,
  output logic       rxf_n,
  output logic       txe_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [7:0] src_data,
  input  logic       src_valid,
  output logic       src_ready,
  output logic [7:0] snk_data,
  output logic       snk_valid,
  input  logic       snk_ready,
  output logic       proto_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int AW    = DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int PW    = (PRECHARGE > 1) ? $clog2(PRECHARGE) : 1;

  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [PW-1:0] PRE_LOAD = PW'(PRECHARGE - 1);

  localparam logic [1:0] R_IDLE   = 2'd0;
  localparam logic [1:0] R_ACTIVE = 2'd1;
  localparam logic [1:0] R_PRE    = 2'd2;
  localparam logic [0:0] W_IDLE   = 1'b0;
  localparam logic [0:0] W_PRE    = 1'b1;

  logic          rd_q;
  logic          wr_q;
  logic          run;
  logic [1:0]    r_state;
  logic [0:0]    w_state;
  logic [PW-1:0] r_cnt;
  logic [PW-1:0] w_cnt;

  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] rx_wptr;
  logic [AW-1:0] rx_rptr;
  logic [CW-1:0] rx_count;

  logic [7:0]    tx_mem [DEPTH];
  logic [AW-1:0] tx_wptr;
  logic [AW-1:0] tx_rptr;
  logic [CW-1:0] tx_count;

  logic       rx_empty;
  logic       rx_full;
  logic       tx_full;
  logic       both_low;
  logic       rd_start;
  logic       rd_empty_err;
  logic       rx_pop;
  logic       wr_fall;
  logic       wr_accept;
  logic       wr_err;
  logic       lb_push;
  logic       tx_push;
  logic       tx_pop;
  logic       src_push;
  logic       rx_push;
  logic [7:0] rx_push_dat;
  logic       bus_drive;
  logic [7:0] bus_dat;

  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == FULL);
  assign tx_full  = (tx_count == FULL);

  // Both strobes low together is never acted on; each path below requires the other strobe high.
  assign both_low     = !rd_n && !wr_n;
  assign rd_start     = (r_state == R_IDLE) && !rd_n && wr_n && !rx_empty;
  assign rd_empty_err = (r_state == R_IDLE) && !rd_n && wr_n && rx_empty;
  assign rx_pop       = (r_state == R_ACTIVE) && !rd_q && rd_n;
  assign wr_fall      = wr_q && !wr_n && rd_n;

`ifdef FT245_LOOPBACK_EN
  assign wr_accept = wr_fall && (w_state == W_IDLE) && !rx_full;
  assign lb_push   = wr_accept;
  assign tx_push   = 1'b0;
`else
  assign wr_accept = wr_fall && (w_state == W_IDLE) && !tx_full;
  assign lb_push   = 1'b0;
  assign tx_push   = wr_accept;
`endif

  assign wr_err = wr_fall && !wr_accept;

  // A loopback echo owns the RX write port for its cycle, so local pushes are held off.
  assign src_ready   = run && !rx_full && !lb_push;
  assign src_push    = src_valid && src_ready;
  assign rx_push     = src_push || lb_push;
  assign rx_push_dat = lb_push ? in_out_245 : src_data;
  assign tx_pop      = snk_valid && snk_ready;

  assign bus_drive  = !reset && !rd_n && wr_n && (r_state != R_PRE);
  assign bus_dat    = rx_empty ? 8'h00 : rx_mem[rx_rptr];
  assign in_out_245 = bus_drive ? bus_dat : 8'bz;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      rd_q      <= 1'b1;
      wr_q      <= 1'b1;
      run       <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      rd_q <= rd_n;
      wr_q <= wr_n;
      run  <= 1'b1;
      if (both_low || rd_empty_err || wr_err) begin
        proto_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock_in) begin
    if (!reset && rx_push) begin
      rx_mem[rx_wptr] <= rx_push_dat;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) begin
        rx_wptr <= rx_wptr + AW'(1);
      end
      if (rx_pop) begin
        rx_rptr <= rx_rptr + AW'(1);
      end
      rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
    end
  end

  always_ff @(posedge clock_in) begin
    if (!reset && tx_push) begin
      tx_mem[tx_wptr] <= in_out_245;
    end
  end

  // A pop is reflected in snk_valid immediately, a fresh push only one cycle later.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      tx_wptr   <= '0;
      tx_rptr   <= '0;
      tx_count  <= '0;
      snk_valid <= 1'b0;
      snk_data  <= 8'h00;
    end else begin
      if (tx_push) begin
        tx_wptr <= tx_wptr + AW'(1);
      end
      if (tx_pop) begin
        tx_rptr <= tx_rptr + AW'(1);
      end
      tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
      snk_data <= tx_mem[tx_pop ? tx_rptr + AW'(1) : tx_rptr];
`ifdef FT245_LOOPBACK_EN
      snk_valid <= 1'b0;
`else
      snk_valid <= (tx_count - CW'(tx_pop)) != '0;
`endif
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_state <= R_IDLE;
      r_cnt   <= '0;
      rxf_n   <= 1'b1;
    end else begin
      case (r_state)
        R_IDLE: begin
          rxf_n <= rx_empty;
          if (rd_start) begin
            r_state <= R_ACTIVE;
          end
        end
        R_ACTIVE: begin
          rxf_n <= 1'b0;
          if (rx_pop) begin
            rxf_n   <= 1'b1;
            r_cnt   <= PRE_LOAD;
            r_state <= R_PRE;
          end
        end
        R_PRE: begin
          if (r_cnt == '0) begin
            rxf_n   <= rx_empty;
            r_state <= R_IDLE;
          end else begin
            rxf_n <= 1'b1;
            r_cnt <= r_cnt - PW'(1);
          end
        end
        default: begin
          rxf_n   <= 1'b1;
          r_state <= R_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      w_state <= W_IDLE;
      w_cnt   <= '0;
      txe_n   <= 1'b1;
    end else begin
      case (w_state)
        W_IDLE: begin
          txe_n <= tx_full;
          if (wr_accept) begin
            txe_n   <= 1'b1;
            w_cnt   <= PRE_LOAD;
            w_state <= W_PRE;
          end
        end
        default: begin
          if (w_cnt == '0) begin
            txe_n   <= tx_full;
            w_state <= W_IDLE;
          end else begin
            txe_n <= 1'b1;
            w_cnt <= w_cnt - PW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ft245_responder.sv
// Bench for ft245_responder: queue-based reference model, randomized local/master traffic, decoupled output monitors.
module tb_ft245_responder;

  localparam int DEPTH = 16;

  logic       clock_in  = 1'b0;
  logic       reset     = 1'b1;
  logic       rd_n      = 1'b1;
  logic       wr_n      = 1'b1;
  logic [7:0] src_data  = 8'h00;
  logic       src_valid = 1'b0;
  logic       snk_ready = 1'b0;
  logic       src_ready;
  logic       snk_valid;
  logic [7:0] snk_data;
  logic       rxf_n;
  logic       txe_n;
  logic       proto_err;
  logic [7:0] bus_drv   = 8'h00;
  logic       bus_en    = 1'b0;
  wire  [7:0] bus;

  assign bus = bus_en ? bus_drv : 8'bz;

  int checks = 0;
  int passed = 0;

  // Reference model: bytes the master can still read, expected bus values, expected sink bytes.
  logic [7:0] rx_model[$];
  logic [7:0] exp_rd[$];
  logic [7:0] exp_snk[$];
  logic       exp_err = 1'b0;
  logic       rd_prev = 1'b1;

  ft245_responder #(.DEPTH_LOG2(4), .PRECHARGE(2)) dut (
    .clock_in  (clock_in),
    .reset     (reset),
    .in_out_245(bus),
    .rxf_n     (rxf_n),
    .txe_n     (txe_n),
    .rd_n      (rd_n),
    .wr_n      (wr_n),
    .src_data  (src_data),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .snk_data  (snk_data),
    .snk_valid (snk_valid),
    .snk_ready (snk_ready),
    .proto_err (proto_err)
  );

  always #5 clock_in = ~clock_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: expected event did not occur", name);
  endtask

  // Read monitor: compares the bus on the first cycle of every read strobe.
  always @(negedge clock_in) begin
    if (!reset && !rd_n && rd_prev) begin
      if (exp_rd.size() == 0) fail_now("rd_unexpected");
      else check("rd_data", bus, exp_rd.pop_front());
    end
    rd_prev = rd_n;
  end

  // Sink monitor: compares every byte the local consumer accepts.
  always @(negedge clock_in) begin
    if (!reset && snk_valid && snk_ready) begin
      if (exp_snk.size() == 0) fail_now("snk_extra");
      else check("snk_data", snk_data, exp_snk.pop_front());
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic wait_flag(input bit rx);
    int n;
    n = 0;
    while (n < 40) begin
      @(negedge clock_in);
      if ((rx ? rxf_n : txe_n) == 1'b0) break;
      n++;
    end
    if (n >= 40) fail_now(rx ? "rxf_timeout" : "txe_timeout");
    tick();
  endtask

  task automatic do_reset();
    rd_n = 1'b1; wr_n = 1'b1; src_valid = 1'b0; bus_en = 1'b0;
    tick();
    reset = 1'b1;
    repeat (3) tick();
    check("rst_rxf_n", rxf_n, 1'b1);
    check("rst_txe_n", txe_n, 1'b1);
    check("rst_src_ready", src_ready, 1'b0);
    check("rst_snk_valid", snk_valid, 1'b0);
    check("rst_snk_data", snk_data, 8'h00);
    check("rst_proto_err", proto_err, 1'b0);
    reset = 1'b0;
    tick();
    check("post_rxf_n", rxf_n, 1'b1);
    check("post_txe_n", txe_n, 1'b0);
    check("post_src_ready", src_ready, 1'b1);
    check("post_proto_err", proto_err, 1'b0);
    exp_err = 1'b0;
    rx_model.delete(); exp_rd.delete(); exp_snk.delete();
  endtask

  task automatic local_push(input logic [7:0] b);
    src_data = b;
    src_valid = 1'b1;
    @(negedge clock_in);
    check("src_ready", src_ready, 32'(rx_model.size() < DEPTH));
    rx_model.push_back(b);
    tick();
    src_valid = 1'b0;
  endtask

  task automatic master_write(input logic [7:0] b, input bit force_it);
    if (force_it) tick(); else wait_flag(1'b0);
    bus_drv = b; bus_en = 1'b1; wr_n = 1'b0;
`ifdef FT245_LOOPBACK_EN
    if (rx_model.size() < DEPTH) rx_model.push_back(b); else exp_err = 1'b1;
`else
    if (exp_snk.size() < DEPTH) exp_snk.push_back(b); else exp_err = 1'b1;
`endif
    tick();
    wr_n = 1'b1; bus_en = 1'b0;
  endtask

  task automatic master_read(input bit empty_rd);
    if (empty_rd) tick(); else wait_flag(1'b1);
    rd_n = 1'b0;
    if (empty_rd) begin
      exp_rd.push_back(8'h00);
      exp_err = 1'b1;
    end else begin
      exp_rd.push_back(rx_model.pop_front());
    end
    tick(); tick();
    rd_n = 1'b1;
    tick();
    if (!empty_rd) begin
      // rxf_n must stay high for exactly two cycles after the pop edge.
      @(negedge clock_in); check("rxf_pre1", rxf_n, 1'b1);
      @(negedge clock_in); check("rxf_pre2", rxf_n, 1'b1);
      @(negedge clock_in); check("rxf_after_pre", rxf_n, 32'(rx_model.size() == 0));
      tick();
    end
  endtask

  initial begin
    int hi;
    int op;
    logic [7:0] b;

    do_reset();

    local_push(8'hA5);
    local_push(8'h3C);
    master_read(1'b0);
    master_read(1'b0);
    check("rx_proto_err", proto_err, exp_err);

`ifndef FT245_LOOPBACK_EN
    snk_ready = 1'b1;
    master_write(8'h55, 1'b0);
    hi = 0;
    repeat (8) begin
      @(negedge clock_in);
      if (snk_valid) hi++;
    end
    check("snk_pulse_cycles", hi, 1);
    tick();
    check("txe_after_pre", txe_n, 1'b0);
`else
    master_write(8'h41, 1'b0);
    master_read(1'b0);
    check("lb_snk_valid", snk_valid, 1'b0);
`endif

    for (int i = 0; i < 200; i++) begin
      snk_ready = 1'($urandom_range(0, 1));
      op = $urandom_range(0, 3);
      b = 8'($urandom_range(0, 255));
      case (op)
        0: if (rx_model.size() < 12) local_push(b);
`ifdef FT245_LOOPBACK_EN
        1: if (rx_model.size() < 12) master_write(b, 1'b0);
`else
        1: if (exp_snk.size() < 12) master_write(b, 1'b0);
`endif
        2: if (rx_model.size() > 0) master_read(1'b0);
        default: tick();
      endcase
    end
    snk_ready = 1'b1;
    while (rx_model.size() > 0) master_read(1'b0);
    repeat (20) tick();
    check("rand_snk_left", exp_snk.size(), 0);
    check("rand_rd_left", exp_rd.size(), 0);
    check("rand_proto_err", proto_err, exp_err);

`ifndef FT245_LOOPBACK_EN
    snk_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) master_write(8'(i * 7 + 1), 1'b0);
    repeat (5) tick();
    check("txe_full", txe_n, 32'(exp_snk.size() == DEPTH));
    check("snk_valid_full", snk_valid, 32'(exp_snk.size() != 0));
    master_write(8'hEE, 1'b1);
    repeat (3) tick();
    check("proto_err_full", proto_err, exp_err);
    snk_ready = 1'b1;
    repeat (40) tick();
    check("full_drain_left", exp_snk.size(), 0);
    check("full_drain_valid", snk_valid, 1'b0);
`endif

    do_reset();
    master_read(1'b1);
    repeat (2) tick();
    check("proto_err_empty", proto_err, exp_err);
    local_push(8'h5A);
    master_read(1'b0);
    repeat (4) tick();
    check("final_rd_left", exp_rd.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
